// File: rtl/sub_bytes_seq.sv
// Time-multiplexed AES SubBytes: streams a 16-byte state through LANES shared
// sbox instances, LANES bytes per beat, and returns the substituted state.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_state,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_state,
    output logic [8*LANES-1:0]   sbox_lhs,
    input  logic [8*LANES-1:0]   sbox_o,
    output logic                 busy
);

    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = 8 * LANES;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [127:0]  in_buf;
    logic [6:0]    base;
    logic          last_beat;
    logic          accept;

    assign base      = 7'(int'(cnt) * LW);
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign busy      = (state == RUN);
    assign accept    = in_valid && in_ready;

    // in_ready is gated by rst directly so it reads 0 for the whole reset pulse
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = !flush;
            DONE:    in_ready = out_ready && !flush;
            default: in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_comb begin
        sbox_lhs = '0;
        if (state == RUN) sbox_lhs = in_buf[base +: LW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_buf    <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_buf <= in_state;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    out_state[base +: LW] <= sbox_o;
                    if (last_beat) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            in_buf <= in_state;
                            cnt    <= '0;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: algebraic sbox wired to the lanes, transaction-level
// model checked every cycle for LANES=4, directed latency/data checks for 1 and 16.
module tb_sub_bytes_seq;

    logic clk = 1'b0;
    logic rst;
    logic iv [3];
    logic fl [3];
    logic ordy [3];
    logic ir [3];
    logic ov [3];
    logic bz [3];
    logic [127:0] ist [3];
    logic [127:0] ost [3];
    logic [31:0]  lhs4, so4;
    logic [7:0]   lhs1, so1;
    logic [127:0] lhs16, so16;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // multiplicative inverse as x^254, then the AES affine transform
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] r, b, e, s, t;
        r = 8'h01; b = x; e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, b);
            b = gmul(b, b);
        end
        s = r; t = r;
        for (int i = 0; i < 4; i++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_f(input logic [127:0] st);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox_f(st[8*k +: 8]);
        return o;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sb4
        assign so4[8*g +: 8] = sbox_f(lhs4[8*g +: 8]);
    end
    assign so1 = sbox_f(lhs1);
    for (genvar g = 0; g < 16; g++) begin : g_sb16
        assign so16[8*g +: 8] = sbox_f(lhs16[8*g +: 8]);
    end

    sub_bytes_seq #(.LANES(4)) u4 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_state(ist[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]),
        .sbox_lhs(lhs4), .sbox_o(so4), .busy(bz[0])
    );
    sub_bytes_seq #(.LANES(1)) u1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_state(ist[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]),
        .sbox_lhs(lhs1), .sbox_o(so1), .busy(bz[1])
    );
    sub_bytes_seq #(.LANES(16)) u16 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_state(ist[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]),
        .sbox_lhs(lhs16), .sbox_o(so16), .busy(bz[2])
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Transaction model for the LANES=4 instance, compared at every falling edge.
    initial begin : model
        bit m_run, m_hold;
        int m_rem;
        logic [127:0] m_in, m_data;
        logic exp_ir;
        m_run = 0; m_hold = 0; m_rem = 0; m_in = '0; m_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("m_rst_valid", ov[0], 1'b0);
                chk("m_rst_ready", ir[0], 1'b0);
                chk("m_rst_busy", bz[0], 1'b0);
                chk("m_rst_state", ost[0], '0);
                m_run = 0; m_hold = 0;
            end else begin
                exp_ir = !fl[0] && (m_hold ? ordy[0] : !m_run);
                chk("m_in_ready", ir[0], exp_ir);
                chk("m_out_valid", ov[0], m_hold);
                chk("m_busy", bz[0], m_run);
                if (m_hold) chk("m_out_state", ost[0], m_data);
                chk("m_sbox_lhs", lhs4, m_run ? m_in[(4 - m_rem) * 32 +: 32] : 32'h0);
                if (fl[0]) begin
                    m_run = 0; m_hold = 0;
                end else if (iv[0] && exp_ir) begin
                    m_in = ist[0]; m_data = sub_f(ist[0]);
                    m_run = 1; m_rem = 4; m_hold = 0;
                end else if (m_run) begin
                    m_rem--;
                    if (m_rem == 0) begin m_run = 0; m_hold = 1; end
                end else if (m_hold && ordy[0]) begin
                    m_hold = 0;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input int k, input logic [127:0] st, output bit ok);
        logic r;
        iv[k] = 1'b1; ist[k] = st; ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); r = ir[k];
            @(posedge clk);
            if (r) begin ok = 1; break; end
        end
        #2;
        iv[k] = 1'b0;
        if (!ok) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic measure(input int k, input logic [127:0] st, output int lat,
                           output int bc, output logic [127:0] res);
        bit ok;
        accept(k, st, ok);
        lat = -1; bc = 0; res = '0;
        if (ok) begin
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (ov[k]) begin lat = n; res = ost[k]; break; end
                if (bz[k]) bc++;
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, bc, cnt;
        bit ok;
        logic [127:0] res, st;
        int el [3];
        int acc [$];
        logic [127:0] got [$];
        int idx;
        logic r;
        el = '{4, 16, 1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1; ist[k] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", ov[0], 1'b0);
        chk("rst_in_ready", ir[0], 1'b0);
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_out_state", ost[0], '0);
        chk("rst_sbox_lhs", lhs4, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk("ready_after_rst", ir[k], 1'b1);

        chk("sbox_00", sbox_f(8'h00), 8'h63);
        chk("sbox_01", sbox_f(8'h01), 8'h7c);
        chk("sbox_ff", sbox_f(8'hff), 8'h16);
        chk("sbox_53", sbox_f(8'h53), 8'hed);
        chk("sub_fips", sub_f(FIPS_IN), FIPS_OUT);

        // all-zero state
        sync();
        measure(0, '0, lat, bc, res);
        chk("zero_latency", lat, 4);
        chk("zero_busy_cycles", bc, 4);
        chk("zero_result", res, {16{8'h63}});
        sync();

        // FIPS vector through every lane count
        for (int k = 0; k < 3; k++) begin
            measure(k, FIPS_IN, lat, bc, res);
            chk("fips_latency", lat, el[k]);
            chk("fips_busy_cycles", bc, el[k]);
            chk("fips_result", res, FIPS_OUT);
            sync();
        end

        // backpressure: result must hold while out_ready is low
        ordy[0] = 1'b0;
        measure(0, {8{8'hff, 8'h01}}, lat, bc, res);
        chk("bp_result", res, {8{8'h16, 8'h7c}});
        sync();
        iv[0] = 1'b1; ist[0] = {4{$urandom}};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_held", ov[0], 1'b1);
            chk("bp_state_held", ost[0], {8{8'h16, 8'h7c}});
            chk("bp_in_ready_low", ir[0], 1'b0);
        end
        @(posedge clk); #2;
        iv[0] = 1'b0; ordy[0] = 1'b1;
        sync(); sync();

        // back-to-back with alternating states
        acc = {}; got = {}; idx = 0;
        iv[0] = 1'b1; ist[0] = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            r = ir[0];
            if (ov[0] && ordy[0]) got.push_back(ost[0]);
            @(posedge clk); #2;
            if (r && iv[0]) begin
                acc.push_back(cyc);
                idx++;
                if (idx == 6) iv[0] = 1'b0;
                else ist[0] = (idx % 2 == 1) ? {16{8'h53}} : 128'h0;
            end
        end
        chk("b2b_accepts", acc.size(), 6);
        chk("b2b_results", got.size(), 6);
        for (int i = 1; i < acc.size(); i++) chk("b2b_interval", acc[i] - acc[i-1], 5);
        for (int i = 0; i < got.size(); i++)
            chk("b2b_data", got[i], (i % 2 == 1) ? {16{8'hed}} : {16{8'h63}});
        sync();

        // flush during beat 2
        accept(0, FIPS_IN, ok);
        @(posedge clk); @(posedge clk); #2;
        fl[0] = 1'b1;
        @(posedge clk); #2;
        fl[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov[0]) cnt++;
            if (i == 0) chk("flush_busy_low", bz[0], 1'b0);
        end
        chk("flush_no_valid", cnt, 0);
        sync();
        st = {$urandom, $urandom, $urandom, $urandom};
        measure(0, st, lat, bc, res);
        chk("post_flush_latency", lat, 4);
        chk("post_flush_result", res, sub_f(st));
        sync();

        // flush with in_valid while idle must not accept
        fl[0] = 1'b1; iv[0] = 1'b1; ist[0] = {4{$urandom}};
        @(negedge clk);
        chk("flush_idle_ready", ir[0], 1'b0);
        @(posedge clk); #2;
        fl[0] = 1'b0; iv[0] = 1'b0;
        @(negedge clk);
        chk("flush_idle_not_run", bz[0], 1'b0);
        sync();

        // async reset mid-RUN
        accept(0, FIPS_IN, ok);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_run_valid", ov[0], 1'b0);
        chk("rst_run_state", ost[0], '0);
        chk("rst_run_busy", bz[0], 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_run_ready_after", ir[0], 1'b1);
        sync();

        // async reset while holding a result
        ordy[0] = 1'b0;
        measure(0, FIPS_IN, lat, bc, res);
        chk("done_before_rst", res, FIPS_OUT);
        sync();
        rst = 1'b1;
        #1;
        chk("rst_done_valid", ov[0], 1'b0);
        chk("rst_done_state", ost[0], '0);
        @(posedge clk); #2;
        rst = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_done_ready_after", ir[0], 1'b1);
        sync();

        // randomized traffic, checked by the model
        for (int i = 0; i < 600; i++) begin
            iv[0]   = 1'($urandom_range(0, 1));
            ist[0]  = {$urandom, $urandom, $urandom, $urandom};
            ordy[0] = ($urandom_range(0, 3) != 0);
            fl[0]   = ($urandom_range(0, 29) == 0);
            sync();
        end
        iv[0] = 1'b0; fl[0] = 1'b0; ordy[0] = 1'b1;
        repeat (20) sync();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
